// File: rtl/shift_reg_input.sv
// Serial reader for a 74HC165-style parallel-in/serial-out chain: pulses the load line,
// clocks out 2^DATA_WIDTH bits at the i_tick pace and presents them as one word.
module shift_reg_input #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                         CLK,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_tick,
  input  logic                         i_sh_q,
  output logic                         o_sh_load_n,
  output logic                         o_sh_clk,
  output logic [(1<<DATA_WIDTH)-1:0]   o_data,
  output logic                         o_valid,
  output logic                         o_busy
);

  localparam int N = 1 << DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] LAST_BIT = DATA_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    SHIFT_LOW  = 2'd2,
    SHIFT_HIGH = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  last_tick;
  logic                  tick_rise;
  logic [N-1:0]          sreg, sreg_nxt;
  logic [DATA_WIDTH-1:0] bit_cnt, bit_cnt_nxt;
  logic                  load_n_nxt;
  logic                  sh_clk_nxt;
  logic [N-1:0]          data_nxt;
  logic                  valid_nxt;
  logic                  busy_nxt;

  // QH enters at the LSB, so the first bit out of the chain ends up in the MSB.
  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic bit_in);
    return {cur[N-2:0], bit_in};
  endfunction

  assign tick_rise = i_tick & ~last_tick;

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    load_n_nxt  = o_sh_load_n;
    sh_clk_nxt  = o_sh_clk;
    data_nxt    = o_data;
    valid_nxt   = 1'b0;
    busy_nxt    = o_busy;
    unique case (state)
      IDLE: begin
        load_n_nxt = 1'b1;
        sh_clk_nxt = 1'b0;
        busy_nxt   = 1'b0;
        // A tick edge arriving together with the request is deliberately not consumed.
        if (i_start) begin
          state_nxt   = LOAD;
          load_n_nxt  = 1'b0;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
        end
      end
      LOAD: begin
        if (tick_rise) begin
          load_n_nxt = 1'b1;
          state_nxt  = SHIFT_LOW;
        end
      end
      SHIFT_LOW: begin
        if (tick_rise) begin
          sreg_nxt = shift_in(sreg, i_sh_q);
          if (bit_cnt == LAST_BIT) begin
            data_nxt  = shift_in(sreg, i_sh_q);
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            sh_clk_nxt  = 1'b1;
            state_nxt   = SHIFT_HIGH;
          end
        end
      end
      SHIFT_HIGH: begin
        if (tick_rise) begin
          sh_clk_nxt = 1'b0;
          state_nxt  = SHIFT_LOW;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_tick resets high so a tick already high at reset release is not an edge.
  always_ff @(posedge CLK) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_tick   <= 1'b1;
      sreg        <= '0;
      bit_cnt     <= '0;
      o_sh_load_n <= 1'b1;
      o_sh_clk    <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_tick   <= i_tick;
      sreg        <= sreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      o_sh_load_n <= load_n_nxt;
      o_sh_clk    <= sh_clk_nxt;
      o_data      <= data_nxt;
      o_valid     <= valid_nxt;
      o_busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_shift_reg_input.sv
// Bench for shift_reg_input: a 165-chain model feeds QH, a monitor scores every captured word
// against the word loaded into the chain and counts pin activity per capture.
module tb_shift_reg_input;

  localparam int DW = 4;
  localparam int N  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         tick = 1'b1;
  logic         sh_q = 1'b0;
  logic         sh_load_n;
  logic         sh_clk;
  logic [N-1:0] data;
  logic         valid;
  logic         busy;

  shift_reg_input #(.DATA_WIDTH(DW)) dut (
    .CLK        (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_tick     (tick),
    .i_sh_q     (sh_q),
    .o_sh_load_n(sh_load_n),
    .o_sh_clk   (sh_clk),
    .o_data     (data),
    .o_valid    (valid),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Tick source: mode 0 = counter bit 2, mode 1 = random high/low times, mode 2 = manual.
  int   tick_mode = 2;
  logic tick_man  = 1'b1;
  int   tick_cnt  = 0;
  int   hold      = 0;

  initial forever begin
    @(negedge clk);
    #1;
    tick_cnt++;
    case (tick_mode)
      0: tick = tick_cnt[2];
      1: begin
        if (hold == 0) begin
          tick = ~tick;
          hold = $urandom_range(0, 3);
        end else begin
          hold--;
        end
      end
      default: tick = tick_man;
    endcase
  end

  // Chain model and scoreboard, evaluated just after each active edge.
  logic [N-1:0] load_q[$];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] load_val = '0;
  logic [N-1:0] chain = '0;
  logic [N-1:0] exp_word;
  logic         prev_load_n = 1'b1;
  logic         prev_sh_clk = 1'b0;
  logic         prev_busy = 1'b0;
  logic         prev_tick = 1'b1;
  logic         counting = 1'b0;
  int           edge_cnt = 0;
  int           cyc = 0;
  int           n_load = 0;
  int           n_clkrise = 0;
  int           n_valid = 0;
  int           valid_cyc = 0;
  int           load_fall_cyc = 0;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      counting = 1'b0;
    end
    if (prev_load_n === 1'b1 && sh_load_n === 1'b0) begin
      n_load++;
      if (load_q.size() > 0) load_val = load_q.pop_front();
      exp_q.push_back(load_val);
      load_fall_cyc = cyc;
    end
    if (sh_load_n === 1'b0) chain = load_val;
    else if (sh_clk === 1'b1 && prev_sh_clk === 1'b0) begin
      n_clkrise++;
      chain = chain << 1;
    end
    sh_q = chain[N-1];
    if (busy === 1'b1 && prev_busy === 1'b0) begin
      counting = 1'b1;
      edge_cnt = 0;
    end else if (counting && tick === 1'b1 && prev_tick === 1'b0) begin
      edge_cnt++;
    end
    if (valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
      check("tick_edges_per_capture", edge_cnt, 32);
      counting = 1'b0;
      exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : ~data;
      check("captured_word", {16'h0, data}, {16'h0, exp_word});
    end
    prev_load_n = sh_load_n;
    prev_sh_clk = sh_clk;
    prev_busy   = busy;
    prev_tick   = tick;
  end

  task automatic wait_valid(input int target, input int bound, input string name);
    int n = 0;
    while (n_valid < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, n_valid, target);
  endtask

  task automatic manual_run(input int target, input string name);
    int n = 0;
    while (n_valid < target && n < 400) begin
      tick_man = ~tick_man;
      repeat (2) @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, n_valid, target);
  endtask

  task automatic wait_rises(input int target, input string name);
    int n = 0;
    while (n_clkrise < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_clk_rises_reached"}, n_clkrise, target);
  endtask

  task automatic capture(input logic [N-1:0] val, input int mode, input logic [N-1:0] req,
                         input string name);
    int l0, r0, v0;
    load_q.push_back(val);
    tick_mode = mode;
    @(negedge clk);
    l0 = n_load; r0 = n_clkrise; v0 = n_valid;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(v0 + 1, 3000, name);
    repeat (3) @(negedge clk);
    check({name, "_data"}, {16'h0, data}, {16'h0, req});
    check({name, "_load_pulses"}, n_load - l0, 1);
    check({name, "_clk_rises"}, n_clkrise - r0, 15);
    check({name, "_busy_after"}, {31'h0, busy}, 0);
  endtask

  typedef struct {
    logic [N-1:0] value;
    int           mode;
    logic [N-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int l0, r0, v0, v1;
    logic [N-1:0] rv;
    int rm;

    vecs[0] = '{16'hA5C3, 0, 16'hA5C3};
    vecs[1] = '{16'h0000, 0, 16'h0000};
    vecs[2] = '{16'hFFFF, 1, 16'hFFFF};
    vecs[3] = '{16'h8001, 0, 16'h8001};
    vecs[4] = '{16'h1234, 1, 16'h1234};
    vecs[5] = '{16'h7FFE, 1, 16'h7FFE};

    // Reset held with tick and start high.
    rst_n = 1'b0; start = 1'b1; tick_mode = 2; tick_man = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_load_n", {31'h0, sh_load_n}, 1);
    check("rst_sh_clk", {31'h0, sh_clk}, 0);
    check("rst_data", {16'h0, data}, 0);
    check("rst_valid", {31'h0, valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);

    // Release with tick still high: load begins, but no phase advance until a fresh edge.
    load_q.push_back(16'h3C96);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rel_no_adv_high", {31'h0, sh_load_n}, 0);
    check("rel_busy", {31'h0, busy}, 1);
    tick_man = 1'b0;
    repeat (2) @(negedge clk);
    check("rel_no_adv_low", {31'h0, sh_load_n}, 0);
    tick_man = 1'b1;
    @(negedge clk);
    check("rel_adv_on_edge", {31'h0, sh_load_n}, 1);
    manual_run(1, "rel");
    repeat (2) @(negedge clk);
    check("rel_data", {16'h0, data}, 32'h3C96);

    foreach (vecs[i]) capture(vecs[i].value, vecs[i].mode, vecs[i].exp_data, "vec");

    // Start while busy is ignored.
    load_q.push_back(16'hA5C3);
    tick_mode = 0;
    @(negedge clk);
    l0 = n_load; r0 = n_clkrise; v0 = n_valid;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rises(r0 + 5, "busy");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(v0 + 1, 3000, "busy");
    repeat (40) @(negedge clk);
    check("busy_valids", n_valid - v0, 1);
    check("busy_loads", n_load - l0, 1);
    check("busy_data", {16'h0, data}, 32'hA5C3);

    // Continuous captures with start held high.
    load_q.push_back(16'h0001);
    load_q.push_back(16'h8000);
    @(negedge clk);
    l0 = n_load; v0 = n_valid;
    start = 1'b1;
    wait_valid(v0 + 1, 3000, "cont1");
    v1 = valid_cyc;
    check("cont_first_data", {16'h0, data}, 32'h0001);
    wait_valid(v0 + 2, 3000, "cont2");
    start = 1'b0;
    check("cont_second_data", {16'h0, data}, 32'h8000);
    check("cont_load_gap", load_fall_cyc - v1, 1);
    repeat (20) @(negedge clk);
    check("cont_loads", n_load - l0, 2);
    check("cont_busy_after", {31'h0, busy}, 0);

    // Reset after 7 samples.
    load_q.push_back(16'h5555);
    @(negedge clk);
    r0 = n_clkrise; v0 = n_valid;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rises(r0 + 7, "mid");
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_load_n", {31'h0, sh_load_n}, 1);
    check("mid_rst_sh_clk", {31'h0, sh_clk}, 0);
    check("mid_rst_data", {16'h0, data}, 0);
    check("mid_rst_valid", {31'h0, valid}, 0);
    check("mid_rst_busy", {31'h0, busy}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_no_valid", n_valid - v0, 0);
    capture(16'hFFFF, 0, 16'hFFFF, "after_rst");

    // Start coincident with a tick edge in IDLE.
    load_q.push_back(16'h9A3E);
    tick_mode = 2;
    tick_man = 1'b0;
    repeat (3) @(negedge clk);
    l0 = n_load; v0 = n_valid;
    start = 1'b1;
    tick_man = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("coinc_load_low", {31'h0, sh_load_n}, 0);
    repeat (3) @(negedge clk);
    check("coinc_load_held", {31'h0, sh_load_n}, 0);
    tick_man = 1'b0;
    repeat (2) @(negedge clk);
    tick_man = 1'b1;
    @(negedge clk);
    check("coinc_load_release", {31'h0, sh_load_n}, 1);
    manual_run(v0 + 1, "coinc");
    repeat (2) @(negedge clk);
    check("coinc_data", {16'h0, data}, 32'h9A3E);
    check("coinc_loads", n_load - l0, 1);

    // Randomized captures; the reference word is whatever was parallel-loaded into the chain.
    for (int k = 0; k < 12; k++) begin
      rv = N'($urandom);
      rm = $urandom_range(0, 1);
      capture(rv, rm, rv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
